// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - multi-channel time-multiplexed FIR with one serial MAC
// Coefficients stream into a shadow bank and are copied to the active bank only in IDLE.
module fir_filter_mc #(
  parameter int LEN    = 21,
  parameter int NCH    = 2,
  parameter int IN_W   = 18,
  parameter int COEF_W = 25,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = 48,
  parameter int SHIFT  = 33,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int K_W   = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [COEF_W-1:0]       i_cfg_din,
  input  logic                    i_cfg_ce,
  input  logic                    i_cfg_commit,
  output logic [7:0]              o_len,
  input  logic [NCH*IN_W-1:0]     i_in,
  input  logic                    i_valid_in,
  output logic                    o_ready_in,
  output logic [OUT_W-1:0]        o_out,
  output logic [CH_W-1:0]         o_out_ch,
  output logic                    o_out_sat,
  output logic                    o_valid_out
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam logic signed [ACC_W:0] RND  = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                     r_state;
  state_t                     w_next;
  logic signed [IN_W-1:0]     r_x      [NCH][LEN];
  logic signed [COEF_W-1:0]   r_shadow [LEN];
  logic signed [COEF_W-1:0]   r_active [LEN];
  logic [K_W-1:0]             r_wptr;
  logic [K_W-1:0]             r_k;
  logic [CH_W-1:0]            r_ch;
  logic                       r_pending;
  logic signed [ACC_W-1:0]    r_acc;

  logic                       w_accept;
  logic                       w_apply;
  logic                       w_last_k;
  logic                       w_last_ch;
  logic signed [IN_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W:0]      w_sum;
  logic signed [ACC_W:0]      w_r;
  logic                       w_hi;
  logic                       w_lo;

  assign o_len      = 8'(LEN);
  assign o_ready_in = (r_state == S_IDLE);
  assign w_accept   = i_valid_in && (r_state == S_IDLE);
  assign w_apply    = (r_state == S_IDLE) && (r_pending || i_cfg_commit);
  assign w_last_k   = (r_k == K_W'(LEN - 1));
  assign w_last_ch  = (r_ch == CH_W'(NCH - 1));

  assign w_prod     = r_active[r_k] * r_x[r_ch][r_k];
  assign w_prod_ext = ACC_W'(w_prod);
  // Extra guard bit keeps the rounding add from wrapping near full scale.
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + RND;
  assign w_r        = w_sum >>> SHIFT;
  assign w_hi       = (w_r > MAXV);
  assign w_lo       = (w_r < MINV);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (w_last_k) w_next = S_OUT;
      S_OUT:   w_next = w_last_ch ? S_IDLE : S_MAC;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LEN; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_wptr    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_cfg_ce) r_shadow[r_wptr] <= i_cfg_din;
      if (w_apply) begin
        // A word written on the commit cycle bypasses the shadow so it lands in the copy.
        for (int i = 0; i < LEN; i++)
          r_active[i] <= (i_cfg_ce && (r_wptr == K_W'(i))) ? i_cfg_din : r_shadow[i];
        r_pending <= 1'b0;
        r_wptr    <= '0;
      end else begin
        if (i_cfg_ce)     r_wptr    <= w_last_wptr(r_wptr) ? '0 : r_wptr + K_W'(1);
        if (i_cfg_commit) r_pending <= 1'b1;
      end
    end
  end

  function automatic logic w_last_wptr(input logic [K_W-1:0] p);
    return (p == K_W'(LEN - 1));
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < LEN; k++)
          r_x[c][k] <= '0;
      r_k         <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
      o_out       <= '0;
      o_out_ch    <= '0;
      o_out_sat   <= 1'b0;
      o_valid_out <= 1'b0;
    end else begin
      o_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int c = 0; c < NCH; c++) begin
              for (int k = LEN - 1; k > 0; k--)
                r_x[c][k] <= r_x[c][k-1];
              r_x[c][0] <= i_in[c*IN_W +: IN_W];
            end
            r_ch  <= '0;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (!w_last_k) r_k <= r_k + K_W'(1);
        end
        S_OUT: begin
          o_out       <= w_hi ? OMAX : (w_lo ? OMIN : w_r[OUT_W-1:0]);
          o_out_sat   <= w_hi || w_lo;
          o_out_ch    <= r_ch;
          o_valid_out <= 1'b1;
          r_ch        <= r_ch + CH_W'(1);
          r_k         <= '0;
          r_acc       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb/tb_fir_filter_mc.sv - randomized self-checking bench for fir_filter_mc
// Reference model computes each output as a direct dot product over the sample history.
module tb_fir_filter_mc;

  localparam int LEN    = 21;
  localparam int NCH    = 2;
  localparam int IN_W   = 18;
  localparam int COEF_W = 25;
  localparam int OUT_W  = 8;
  localparam int ACC_W  = 48;
  localparam int SHIFT  = 33;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FR     = NCH * (LEN + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [COEF_W-1:0]   cfg_din;
  logic                cfg_ce;
  logic                cfg_commit;
  logic [7:0]          len;
  logic [NCH*IN_W-1:0] din;
  logic                valid_in;
  logic                ready_in;
  logic [OUT_W-1:0]    dout;
  logic [CH_W-1:0]     out_ch;
  logic                out_sat;
  logic                valid_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_filter_mc #(
    .LEN(LEN), .NCH(NCH), .IN_W(IN_W), .COEF_W(COEF_W),
    .OUT_W(OUT_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_din(cfg_din), .i_cfg_ce(cfg_ce), .i_cfg_commit(cfg_commit),
    .o_len(len),
    .i_in(din), .i_valid_in(valid_in), .o_ready_in(ready_in),
    .o_out(dout), .o_out_ch(out_ch), .o_out_sat(out_sat), .o_valid_out(valid_out)
  );

  longint m_shadow [LEN];
  longint m_active [LEN];
  int     m_wptr;
  bit     m_pending;
  longint m_hist [NCH][LEN];
  longint m_new  [NCH];
  longint m_tmp  [LEN];
  longint exp_out [NCH];
  bit     exp_sat [NCH];
  logic [OUT_W-1:0] got_out [NCH];
  logic             got_sat [NCH];

  function automatic void model_reset();
    for (int i = 0; i < LEN; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < LEN; k++)
        m_hist[c][k] = 0;
    m_wptr    = 0;
    m_pending = 0;
  endfunction

  function automatic void model_apply();
    for (int i = 0; i < LEN; i++) m_active[i] = m_shadow[i];
    m_wptr    = 0;
    m_pending = 0;
  endfunction

  function automatic void model_frame();
    longint acc;
    longint r;
    longint half;
    half = 1;
    half = half <<< (SHIFT - 1);
    for (int c = 0; c < NCH; c++) begin
      for (int k = LEN - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = m_new[c];
      acc = 0;
      for (int k = 0; k < LEN; k++) acc += m_active[k] * m_hist[c][k];
      r = (acc + half) >>> SHIFT;
      exp_sat[c] = 1'b0;
      if (r > 127)  begin r = 127;  exp_sat[c] = 1'b1; end
      if (r < -128) begin r = -128; exp_sat[c] = 1'b1; end
      exp_out[c] = r;
    end
  endfunction

  function automatic longint rand_sample();
    logic [IN_W-1:0] v;
    v = IN_W'($urandom);
    return longint'($signed(v));
  endfunction

  function automatic longint rand_coef();
    int mb;
    longint v;
    mb = $urandom_range(8, 24);
    v  = longint'($urandom_range(0, (1 << mb) - 1));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    valid_in = 1'b0;
    cfg_ce = 1'b0;
    cfg_commit = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_op(input longint w, input bit ce, input bit commit);
    bit idle;
    cfg_din    = w[COEF_W-1:0];
    cfg_ce     = ce;
    cfg_commit = commit;
    idle       = ready_in;
    @(posedge clk);
    #1 cfg_ce = 1'b0;
    cfg_commit = 1'b0;
    if (ce) begin
      m_shadow[m_wptr] = longint'($signed(w[COEF_W-1:0]));
      m_wptr = (m_wptr + 1) % LEN;
    end
    if (commit) m_pending = 1'b1;
    if (idle && m_pending) model_apply();
  endtask

  task automatic load_set(input bit commit_with_last);
    for (int i = 0; i < LEN; i++)
      cfg_op(m_tmp[i], 1'b1, commit_with_last && (i == LEN - 1));
    if (!commit_with_last) cfg_op(0, 1'b0, 1'b1);
  endtask

  task automatic start_frame(input bit keep_valid, output time t_acc);
    int guard;
    guard = 0;
    for (int c = 0; c < NCH; c++) din[c*IN_W +: IN_W] = m_new[c][IN_W-1:0];
    valid_in = 1'b1;
    while (!ready_in && guard < 400) begin
      @(posedge clk);
      #1 guard++;
    end
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b exp 1", ready_in);
    end
    if (m_pending) model_apply();
    model_frame();
    @(posedge clk);
    t_acc = $time;
    #1 if (!keep_valid) valid_in = 1'b0;
  endtask

  task automatic collect_frame();
    bit exp_v;
    int c;
    for (int n = 1; n <= FR; n++) begin
      @(posedge clk);
      #1;
      exp_v = (n % (LEN + 1)) == 0;
      c = n / (LEN + 1) - 1;
      checks++;
      if (valid_out !== exp_v) begin
        errors++;
        $display("FAIL valid_out_timing edge T+%0d got %b exp %b", n, valid_out, exp_v);
      end
      checks++;
      if (ready_in !== (n == FR)) begin
        errors++;
        $display("FAIL ready_in edge T+%0d got %b exp %b", n, ready_in, n == FR);
      end
      if (exp_v) begin
        got_out[c] = dout;
        got_sat[c] = out_sat;
        checks++;
        if (dout !== exp_out[c][OUT_W-1:0]) begin
          errors++;
          $display("FAIL out ch%0d got %0d exp %0d", c, $signed(dout), exp_out[c]);
        end
        checks++;
        if (out_sat !== exp_sat[c]) begin
          errors++;
          $display("FAIL out_sat ch%0d got %b exp %b", c, out_sat, exp_sat[c]);
        end
        checks++;
        if (out_ch !== CH_W'(c)) begin
          errors++;
          $display("FAIL out_ch got %0d exp %0d", out_ch, c);
        end
      end
    end
  endtask

  task automatic send_frame();
    time t;
    start_frame(1'b0, t);
    collect_frame();
  endtask

  task automatic set_single_tap(input int idx, input longint c);
    for (int i = 0; i < LEN; i++) m_tmp[i] = 0;
    m_tmp[idx] = c;
  endtask

  task automatic test_reset();
    do_reset(10);
    checks++;
    if (dout !== '0 || out_ch !== '0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %0d/%0d/%b exp 0/0/0", dout, out_ch, out_sat);
    end
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake got valid_out=%b ready_in=%b exp 0 1", valid_out, ready_in);
    end
    checks++;
    if (len !== 8'd21) begin
      errors++;
      $display("FAIL len got %0d exp 21", len);
    end
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (got_out[c] !== '0) begin
        errors++;
        $display("FAIL zero_coef ch%0d got %0d exp 0", c, $signed(got_out[c]));
      end
    end
  endtask

  task automatic test_gain_tap();
    do_reset(3);
    set_single_tap(0, 64'h8CCCCC);
    load_set(1'b0);
    m_new[0] = 65536;
    m_new[1] = -65536;
    send_frame();
    checks++;
    if ($signed(got_out[0]) != 70 || $signed(got_out[1]) != -70 || got_sat[0] || got_sat[1]) begin
      errors++;
      $display("FAIL gain_tap got %0d,%0d exp 70,-70", $signed(got_out[0]), $signed(got_out[1]));
    end
  endtask

  task automatic test_tap_order();
    do_reset(3);
    set_single_tap(3, 64'h800000);
    load_set(1'b1);
    for (int f = 0; f < 7; f++) begin
      m_new[0] = (f == 0) ? 65536 : 0;
      m_new[1] = 0;
      send_frame();
      checks++;
      if ($signed(got_out[0]) != ((f == 3) ? 64 : 0) || got_out[1] !== '0) begin
        errors++;
        $display("FAIL tap_order frame %0d got %0d,%0d exp %0d,0",
                 f, $signed(got_out[0]), $signed(got_out[1]), (f == 3) ? 64 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(3);
    set_single_tap(0, 64'h800000);
    load_set(1'b1);
    m_new[0] = 131071;
    m_new[1] = -131072;
    send_frame();
    checks++;
    if ($signed(got_out[0]) != 127 || got_sat[0] !== 1'b1 ||
        $signed(got_out[1]) != -128 || got_sat[1] !== 1'b0) begin
      errors++;
      $display("FAIL saturation got %0d/%b,%0d/%b exp 127/1,-128/0",
               $signed(got_out[0]), got_sat[0], $signed(got_out[1]), got_sat[1]);
    end
  endtask

  task automatic test_random();
    int gap;
    do_reset(3);
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < LEN; i++) m_tmp[i] = rand_coef();
      load_set($urandom_range(0, 1) == 1);
      for (int f = 0; f < 3; f++) begin
        for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        send_frame();
      end
    end
  endtask

  task automatic test_deferred_commit();
    do_reset(3);
    for (int i = 0; i < LEN; i++) m_tmp[i] = rand_coef();
    load_set(1'b1);
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
    fork
      begin
        for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
        send_frame();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) cfg_op(rand_coef(), 1'b1, i == 5);
      end
    join
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
    cfg_op(rand_coef(), 1'b1, 1'b1);
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
  endtask

  task automatic test_back_to_back();
    time t;
    time prev;
    do_reset(3);
    for (int i = 0; i < LEN; i++) m_tmp[i] = rand_coef();
    load_set(1'b1);
    prev = 0;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
      start_frame(1'b1, t);
      if (f > 0) begin
        checks++;
        if ((t - prev) != time'((FR + 1) * 10)) begin
          errors++;
          $display("FAIL accept_interval got %0t exp %0d", t - prev, (FR + 1) * 10);
        end
      end
      prev = t;
      collect_frame();
    end
    valid_in = 1'b0;
  endtask

  task automatic test_abort();
    time t;
    bit seen;
    do_reset(3);
    set_single_tap(0, 64'h800000);
    load_set(1'b1);
    for (int c = 0; c < NCH; c++) m_new[c] = 65536;
    start_frame(1'b0, t);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 seen |= valid_out;
    end
    rst_n = 1'b1;
    model_reset();
    repeat (60) begin
      @(posedge clk);
      #1 seen |= valid_out;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid_out got 1 exp 0");
    end
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
    for (int i = 0; i < LEN; i++) m_tmp[i] = rand_coef();
    load_set(1'b1);
    for (int c = 0; c < NCH; c++) m_new[c] = rand_sample();
    send_frame();
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_din    = '0;
    cfg_ce     = 1'b0;
    cfg_commit = 1'b0;
    din        = '0;
    valid_in   = 1'b0;
    #1;
    test_reset();
    test_gain_tap();
    test_tap_order();
    test_saturation();
    test_deferred_commit();
    test_back_to_back();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_mc.md
# fir_filter_mc

Multi-channel, time-multiplexed FIR filter with one serial MAC and a double-buffered coefficient bank. It is the parametrised successor to `fir_filter`. It accepts one frame per handshake, holding one sample per channel, and filters every channel with the same LEN-tap coefficient set. It emits one rounded, saturated result per channel. It sits between the front-end sample source and the output/decimation stage of the receive path. Coefficients are streamed in on the same serial config port as `fir_filter` and take effect atomically at a frame boundary.

## Interface
- LEN, 21, number of taps (1..32)
- NCH, 2, channel count (1..8)
- IN_W, 18, signed input sample width
- COEF_W, 25, signed coefficient width, Q1.23 (1.0 = 0x800000)
- OUT_W, 8, signed output width
- ACC_W, 48, accumulator width; must be >= IN_W+COEF_W+clog2(LEN)
- SHIFT, 33, right shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_din  in  COEF_W  coefficient word
- cfg_ce  in  1  write cfg_din to shadow[wptr], then wptr++
- cfg_commit  in  1  request shadow->active copy
- len  out  8  constant LEN
- in  in  NCH*IN_W  frame; channel c is at bits [c*IN_W +: IN_W]
- valid_in  in  1  frame valid
- ready_in  out  1  high in IDLE only
- out  out  OUT_W  filtered sample
- out_ch  out  clog2(NCH) (min 1)  channel index of `out`
- out_sat  out  1  saturation occurred on this output
- valid_out  out  1  one-cycle strobe per channel result

## Operation
- Reset (reset=0, async) clears:
  - all delay lines, shadow coefficients and active coefficients to 0; wptr=0; commit_pending=0;
  - state=IDLE; out=0, out_ch=0, out_sat=0, valid_out=0; ready_in=1.
- Coefficient load:
  - each cfg_ce cycle writes shadow[wptr]; wptr wraps LEN-1 -> 0.
  - cfg_commit sets commit_pending.
- Commit apply:
  - the copy shadow->active happens at any edge where state=IDLE and (commit_pending or cfg_commit); commit_pending clears and wptr resets to 0.
  - if cfg_ce and cfg_commit occur in the same cycle, that word is included in the copy.
  - a commit arriving outside IDLE waits, so the frame in progress always uses one coefficient set.
- FSM states: IDLE, MAC, OUT.
  - IDLE: on valid_in&&ready_in, shift each channel's delay line (x[c][k] <= x[c][k-1], x[c][0] <= new sample). Then ch=0, k=0, acc=0 -> MAC.
  - MAC: acc += active[k] * x[ch][k] (signed, full precision). At k=LEN-1 -> OUT, else k++.
  - OUT: register out/out_ch/out_sat and pulse valid_out. If ch=NCH-1 -> IDLE; else ch++, k=0, acc=0 -> MAC.
- Arithmetic:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 iff a clamp occurred.
- valid_in outside IDLE is ignored; no sample is lost or duplicated, because ready_in=0 there.
- Reset mid-frame aborts the frame; no partial valid_out is produced.

## Timing
- Frame accepted at edge T.
  - MAC for channel c occupies edges T+1+c(LEN+1) .. T+LEN+c(LEN+1).
  - valid_out for channel c is high in the cycle after edge T+(c+1)(LEN+1).
- ready_in is low from the cycle after T until state returns to IDLE.
- Maximum throughput is one frame per NCH(LEN+1)+1 cycles: 45 at defaults.
- Commit latency: active coefficients are updated no later than the first IDLE edge after cfg_commit.

## Test plan
- Reset: hold reset=0 for 10 cycles, then release.
  - Outputs are 0, valid_out=0 and ready_in=1.
  - The first frame, with all coefficients 0, gives out=0 on both channels.
- Gain tap: load coef0=0x8CCCCC (1.1) and 20 zeros, then commit. Send ch0=65536, ch1=-65536.
  - Outputs are ch0 out=70 and ch1 out=-70, with out_sat=0.
  - valid_out fires at T+22 (ch0) and T+44 (ch1).
- Tap order: load coef3=0x800000 (others 0) and commit. Drive a ch0 impulse 65536 followed by zero frames.
  - ch0 out=64 on frame index 3 only and 0 on all other frames; ch1 is always 0.
- Saturation: coef0=0x800000.
  - Input 131071 gives out=127 with out_sat=1.
  - Input -131072 gives out=-128 with out_sat=0.
- Deferred commit: load and commit new coefficients while in MAC.
  - The current frame's outputs use the old set; the next frame uses the new set.
  - wptr=0 afterwards.
- Handshake and abort:
  - Hold valid_in=1 continuously: frames are accepted exactly every 45 cycles.
  - Assert reset=0 mid-MAC: valid_out never pulses, and after release the first frame behaves as it does after a fresh reset.
